// File: rtl/idct_row_sched_if.sv
// Bundle of the controller, coefficient-RAM, engine and result signals of the
// row-IDCT sequencer. The slave modport is the sequencer's view.
interface idct_row_sched_if #(
    parameter int WIDTH_X = 16,
    parameter int ADDR_W  = 8
);
    logic               start;
    logic               blk8;
    logic [ADDR_W-1:0]  base_addr;
    logic               busy;
    logic               done;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [WIDTH_X-1:0] rd_data;
    logic [1:0]         idct4;
    logic [WIDTH_X-1:0] x_out;
    logic [WIDTH_X-1:0] eng_y;
    logic               res_valid;
    logic [WIDTH_X-1:0] res_data;
    logic               res_last;

    modport master (
        output start, blk8, base_addr, rd_data, eng_y,
        input  busy, done, rd_en, rd_addr, idct4, x_out, res_valid, res_data, res_last
    );

    modport slave (
        input  start, blk8, base_addr, rd_data, eng_y,
        output busy, done, rd_en, rd_addr, idct4, x_out, res_valid, res_data, res_last
    );
endinterface

// File: rtl/idct_row_sched.sv
// Row-IDCT sequencer: streams a 4x4 or 8x8 coefficient block from RAM into the
// row engine one coefficient per cycle and frames the engine's serial results.
module idct_row_sched #(
    parameter int WIDTH_X = 16,
    parameter int ADDR_W  = 8,
    parameter int ENG_LAT = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    idct_row_sched_if.slave  bus
);
    localparam int CNT_W = 7;
    localparam int LAT_W = $clog2(ENG_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic               blk8_q, blk8_d;
    logic               rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]   x_cnt_q, x_cnt_d;
    logic [WIDTH_X-1:0] x_out_q, x_out_d;
    logic [1:0]         idct4_q, idct4_d;
    logic               lat_run_q, lat_run_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic               res_valid_q, res_valid_d;
    logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;

    logic [CNT_W-1:0]   n_len;
    logic [CNT_W-1:0]   n_last;
    logic               accept;
    logic               res_last;

    assign n_len    = blk8_q ? CNT_W'(64) : CNT_W'(16);
    assign n_last   = n_len - CNT_W'(1);
    assign accept   = (state_q == S_IDLE) && bus.start;
    assign res_last = res_valid_q && (res_cnt_q == n_last);

    // NOTE: every *_d gets its hold value first, so no path through this block
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        blk8_d      = blk8_q;
        rd_en_d     = rd_en_q;
        rd_addr_d   = rd_addr_q;
        rd_cnt_d    = rd_cnt_q;
        x_cnt_d     = x_cnt_q;
        x_out_d     = x_out_q;
        idct4_d     = idct4_q;
        lat_run_d   = lat_run_q;
        lat_cnt_d   = lat_cnt_q;
        res_valid_d = res_valid_q;
        res_cnt_d   = res_cnt_q;

        // Address walk runs on its own once started; rd_cnt_q is the index being issued.
        if (rd_en_q) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            rd_cnt_d  = rd_cnt_q + CNT_W'(1);
            if (rd_cnt_q == n_last) begin
                rd_en_d = 1'b0;
            end
        end

        // Latency counter is anchored on the first coefficient, independent of the FSM.
        if (lat_run_q) begin
            lat_cnt_d = lat_cnt_q + LAT_W'(1);
            if (lat_cnt_q == LAT_W'(ENG_LAT - 1)) begin
                lat_run_d   = 1'b0;
                res_valid_d = 1'b1;
                res_cnt_d   = '0;
            end
        end

        if (res_valid_q) begin
            if (res_cnt_q == n_last) begin
                res_valid_d = 1'b0;
                res_cnt_d   = '0;
            end else begin
                res_cnt_d = res_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    blk8_d    = bus.blk8;
                    rd_en_d   = 1'b1;
                    rd_addr_d = bus.base_addr + ADDR_W'(1);
                    rd_cnt_d  = CNT_W'(1);
                    idct4_d   = bus.blk8 ? 2'b10 : 2'b01;
                    state_d   = S_PRIME;
                end
            end
            S_PRIME: begin
                x_out_d   = bus.rd_data;
                x_cnt_d   = CNT_W'(1);
                lat_run_d = 1'b1;
                lat_cnt_d = '0;
                state_d   = S_STREAM;
            end
            S_STREAM: begin
                if (x_cnt_q == n_len) begin
                    x_out_d = '0;
                    x_cnt_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    x_out_d = bus.rd_data;
                    x_cnt_d = x_cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (res_last) begin
                    idct4_d = 2'b00;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            blk8_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_cnt_q    <= '0;
            x_cnt_q     <= '0;
            x_out_q     <= '0;
            idct4_q     <= 2'b00;
            lat_run_q   <= 1'b0;
            lat_cnt_q   <= '0;
            res_valid_q <= 1'b0;
            res_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            blk8_q      <= blk8_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            rd_cnt_q    <= rd_cnt_d;
            x_cnt_q     <= x_cnt_d;
            x_out_q     <= x_out_d;
            idct4_q     <= idct4_d;
            lat_run_q   <= lat_run_d;
            lat_cnt_q   <= lat_cnt_d;
            res_valid_q <= res_valid_d;
            res_cnt_q   <= res_cnt_d;
        end
    end

    // The first read is issued in the start cycle so coefficient 0 reaches the
    // engine two cycles after start.
    assign bus.rd_en     = rd_en_q || accept;
    assign bus.rd_addr   = accept ? bus.base_addr : rd_addr_q;
    assign bus.busy      = (state_q == S_PRIME) || (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.idct4     = idct4_q;
    assign bus.x_out     = x_out_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_valid_q ? bus.eng_y : '0;
    assign bus.res_last  = res_last;
endmodule

// File: doc/idct_row_sched.md
Name: idct_row_sched

Overview:
- Sequencer that feeds the row-IDCT engine one coefficient per cycle from a coefficient buffer.
- Drives the engine's transform-size select and collects its serial output stream.
- Flags each valid result sample and signals block completion.
- Sits between the block-level controller (start/done) and the row engine plus its coefficient RAM.

Parameters:
- WIDTH_X, 16, coefficient and result sample width.
- ADDR_W, 8, coefficient buffer address width.
- ENG_LAT, 13, cycles from the first coefficient presented on x_out to the first valid sample on eng_y.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a block when idle
- blk8  in  1  sampled with start: 0 = 4x4 block (4-point rows), 1 = 8x8 block (8-point rows)
- base_addr  in  ADDR_W  sampled with start: address of coefficient 0 of the block
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last result sample
- rd_en  out  1  coefficient RAM read enable
- rd_addr  out  ADDR_W  coefficient RAM read address
- rd_data  in  WIDTH_X  RAM read data, valid one cycle after rd_en
- idct4  out  2  engine size select: 00 idle, 01 4-point, 10 8-point
- x_out  out  WIDTH_X  coefficient to the engine
- eng_y  in  WIDTH_X  engine serial output
- res_valid  out  1  res_data holds a valid result
- res_data  out  WIDTH_X  result sample
- res_last  out  1  marks the final result of the block

Behaviour:
- Reset (async, rst_n low): FSM goes to IDLE. busy, done, rd_en, res_valid and res_last are 0. idct4 = 00. x_out, rd_addr and res_data are 0. All counters clear.
- Block length N = 16 (blk8=0) or 64 (blk8=1).
- Coefficients are read row-major, addresses base_addr .. base_addr+N-1, incremented by 1 and wrapping modulo 2^ADDR_W.
- Each 8-cycle engine slot carries either one 8-point row or two consecutive 4-point rows.
- FSM IDLE:
  - start=1 latches blk8 and base_addr, sets busy, asserts rd_en with rd_addr=base_addr, then moves to PRIME.
  - start=0 holds IDLE.
- FSM PRIME (1 cycle):
  - rd_en stays high; rd_addr advances.
  - idct4 is driven to 01 or 10 this cycle and held constant until DRAIN exits.
- FSM STREAM:
  - x_out <= rd_data every cycle. Cycle 0 of STREAM carries coefficient 0.
  - rd_en drops after address base_addr+N-1 has been issued.
  - After N coefficients, x_out returns to 0 and the FSM moves to DRAIN.
- FSM DRAIN:
  - idct4 stays asserted so the engine's slot counter keeps running.
  - Count cycles from the first coefficient. At count ENG_LAT, res_valid rises and stays high for exactly N consecutive cycles, with res_data = eng_y.
  - res_last is high on the N-th sample only.
  - The cycle after res_last, move to DONE.
- FSM DONE (1 cycle): done=1, busy=0, idct4=00, then return to IDLE.
- A start pulse while busy=1 (including the DONE cycle) is ignored. No queuing.
- The result counter and coefficient counter are independent, so streaming and result capture overlap.
- The total block time from start to done is 1 + 1 + ENG_LAT + N cycles.
- rst_n asserted mid-block aborts immediately: idct4 drops to 00 and no done pulse is produced. After release the FSM is in IDLE and accepts a new start.
- blk8 and base_addr changing while busy have no effect.

Test Plan:
- Reset → busy=0, idct4=00, res_valid=0, rd_en=0; hold 10 cycles and all stay low.
- start with blk8=0, base_addr=0x20, RAM[i]=i → rd_addr 0x20..0x2F, x_out 0x20..0x2F on 16 consecutive cycles, idct4=01, res_valid high for exactly 16 cycles starting ENG_LAT after the first x_out, res_last on the 16th, done 1 cycle later.
- start with blk8=1, base_addr=0xF8 → rd_addr wraps 0xF8..0xFF then 0x00..0x37, idct4=10, 64 result samples, done at cycle 1+1+13+64=79 after start.
- start pulsed again at cycle 5 and on the DONE cycle of a 4x4 block → both ignored; exactly one done pulse and 16 results.
- rst_n low for 1 cycle during DRAIN of an 8x8 block → idct4=00 and res_valid=0 immediately, no done; a following 4x4 start completes normally with 16 results.
- Reference-model check: a DC-only 8x8 block with coef0=64 → every row-0 result equals the engine's golden model and all other rows are 0.
